// File: rtl/bus_source_latch.sv
// Purpose: latches a one-hot-selected register source onto the datapath bus and counts multi-select contention; define BUS_SOURCE_LATCH_PARITY_EN for the bus_parity output.
// Latency: 1 cycle from an accepted request to bus_valid/busMuxOut.
// Backpressure: sel_ready = !bus_valid | bus_ready; a held bus stays frozen and stalled requests are ignored.
module bus_source_latch #(
    parameter int BITS    = 32,
    parameter int SOURCES = 24,
    parameter int IDXW    = $clog2(SOURCES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BITS*SOURCES-1:0] registerStream,
    input  logic [SOURCES-1:0]      registerSelect,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    output logic [BITS-1:0]         busMuxOut,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    output logic [IDXW-1:0]         src_idx,
    output logic                    err_multi,
    output logic [7:0]              err_count,
`ifdef BUS_SOURCE_LATCH_PARITY_EN
    output logic                    bus_parity,
`endif
    input  logic                    err_clear
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    state_t          nextState;
    logic            accept;
    logic            selOneHot;
    logic            selMulti;
    logic            doCapture;
    logic            doError;
    logic [IDXW-1:0] hitIdx;
    logic [BITS-1:0] hitData;

    assign bus_valid = (state == HOLD);
    assign sel_ready = !bus_valid || bus_ready;
    assign accept    = sel_valid && sel_ready;
    assign selOneHot = $onehot(registerSelect);
    assign selMulti  = (|registerSelect) && !selOneHot;
    assign doCapture = accept && selOneHot;
    assign doError   = accept && selMulti;

    // Encoder is only meaningful when the select is one-hot.
    always_comb begin
        hitIdx = '0;
        for (int i = 0; i < SOURCES; i++) begin
            if (registerSelect[i]) begin
                hitIdx = IDXW'(i);
            end
        end
    end

    assign hitData = registerStream[int'(hitIdx)*BITS +: BITS];

    always_comb begin
        nextState = state;
        if (doCapture) begin
            nextState = HOLD;
        end else if (state == HOLD && bus_ready) begin
            nextState = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Data and index are not cleared when the bus drains; they hold the last transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            busMuxOut <= '0;
            src_idx   <= '0;
        end else if (doCapture) begin
            busMuxOut <= hitData;
            src_idx   <= hitIdx;
        end
    end

`ifdef BUS_SOURCE_LATCH_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_parity <= 1'b0;
        end else if (doCapture) begin
            bus_parity <= ^hitData;
        end
    end
`endif

    // A new contention event in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_multi <= 1'b0;
            err_count <= 8'd0;
        end else if (doError) begin
            err_multi <= 1'b1;
            if (err_clear) begin
                err_count <= 8'd1;
            end else if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end else if (err_clear) begin
            err_multi <= 1'b0;
            err_count <= 8'd0;
        end
    end

endmodule

// File: tb/tb_bus_source_latch.sv
// Randomized and directed bench for bus_source_latch against a transaction-level reference model.
module tb_bus_source_latch;

    localparam int BITS    = 32;
    localparam int SOURCES = 24;
    localparam int IDXW    = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [BITS*SOURCES-1:0] registerStream;
    logic [SOURCES-1:0]      registerSelect;
    logic                    sel_valid;
    logic                    sel_ready;
    logic [BITS-1:0]         busMuxOut;
    logic                    bus_valid;
    logic                    bus_ready;
    logic [IDXW-1:0]         src_idx;
    logic                    err_multi;
    logic [7:0]              err_count;
    logic                    err_clear;
`ifdef BUS_SOURCE_LATCH_PARITY_EN
    logic                    bus_parity;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        mValid;
    logic [31:0] mBus;
    int          mIdx;
    logic        mErr;
    int          mCnt;

    always #5 clk = ~clk;

    bus_source_latch dut (
        .clk(clk),
        .reset(reset),
        .registerStream(registerStream),
        .registerSelect(registerSelect),
        .sel_valid(sel_valid),
        .sel_ready(sel_ready),
        .busMuxOut(busMuxOut),
        .bus_valid(bus_valid),
        .bus_ready(bus_ready),
        .src_idx(src_idx),
        .err_multi(err_multi),
        .err_count(err_count),
`ifdef BUS_SOURCE_LATCH_PARITY_EN
        .bus_parity(bus_parity),
`endif
        .err_clear(err_clear)
    );

    task automatic set_src(input int i, input logic [31:0] v);
        registerStream[i*BITS +: BITS] = v;
    endtask

    task automatic randomize_stream();
        for (int i = 0; i < SOURCES; i++) set_src(i, $urandom);
    endtask

    // Advance one clock, predicting the outcome from the inputs presented for this edge.
    task automatic tick();
        int   ones;
        logic acc;
        ones = $countones(registerSelect);
        acc  = sel_valid && (!mValid || bus_ready);
        if (reset) begin
            mValid = 0; mBus = 0; mIdx = 0; mErr = 0; mCnt = 0;
        end else begin
            if (acc && ones == 1) begin
                for (int i = 0; i < SOURCES; i++) begin
                    if (registerSelect[i]) begin
                        mIdx = i;
                        mBus = registerStream[i*BITS +: BITS];
                    end
                end
                mValid = 1;
            end else if (mValid && bus_ready) begin
                mValid = 0;
            end
            if (acc && ones > 1) begin
                mErr = 1;
                mCnt = err_clear ? 1 : ((mCnt < 255) ? mCnt + 1 : 255);
            end else if (err_clear) begin
                mErr = 0;
                mCnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        for (int c = 0; c < 2; c++) begin
            randomize_stream();
            registerSelect = SOURCES'($urandom);
            sel_valid = 1'($urandom);
            bus_ready = 1'($urandom);
            err_clear = 1'($urandom);
            tick();
        end
        bus_ready = 0; sel_valid = 0; err_clear = 0;
        #1;
        checks++;
        if ({bus_valid, busMuxOut, src_idx, err_multi, err_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%0b bus=%h idx=%0d err=%0b cnt=%0d want all 0",
                     bus_valid, busMuxOut, src_idx, err_multi, err_count);
        end
        checks++;
        if (sel_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_sel_ready got %0b want 1", sel_ready);
        end
`ifdef BUS_SOURCE_LATCH_PARITY_EN
        checks++;
        if (bus_parity !== 1'b0) begin
            failures++;
            $display("FAIL reset_parity got %0b want 0", bus_parity);
        end
`endif
        reset = 0;
        tick();
    endtask

    task automatic test_capture();
        randomize_stream();
        set_src(23, 32'hDEADBEEF);
        registerSelect = 24'h1 << 23;
        sel_valid = 1; bus_ready = 1;
        tick();
        checks++;
        if (busMuxOut !== 32'hDEADBEEF || src_idx !== 5'd23 || bus_valid !== 1'b1) begin
            failures++;
            $display("FAIL capture_mdr got bus=%h idx=%0d valid=%0b want DEADBEEF 23 1",
                     busMuxOut, src_idx, bus_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pcVal;
        pcVal = $urandom;
        set_src(16, pcVal);
        registerSelect = 24'h1 << 16;
        sel_valid = 1; bus_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (sel_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_sel_ready cycle %0d got %0b want 0", c, sel_ready);
            end
            tick();
            checks++;
            if (busMuxOut !== 32'hDEADBEEF || src_idx !== 5'd23 || bus_valid !== 1'b1 || err_multi !== 1'b0) begin
                failures++;
                $display("FAIL stall_frozen cycle %0d got bus=%h idx=%0d valid=%0b err=%0b want DEADBEEF 23 1 0",
                         c, busMuxOut, src_idx, bus_valid, err_multi);
            end
            if (c == 2) registerSelect = 24'h3;
        end
        registerSelect = 24'h1 << 16;
        bus_ready = 1;
        tick();
        checks++;
        if (busMuxOut !== pcVal || src_idx !== 5'd16 || bus_valid !== 1'b1) begin
            failures++;
            $display("FAIL release_pc got bus=%h idx=%0d valid=%0b want %h 16 1",
                     busMuxOut, src_idx, bus_valid, pcVal);
        end
    endtask

    task automatic test_multi();
        logic [31:0] held;
        held = busMuxOut;
        registerSelect = 24'h000003;
        sel_valid = 1; bus_ready = 1;
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (err_multi !== 1'b1 || err_count !== 8'd3 || bus_valid !== 1'b0 || busMuxOut !== held) begin
            failures++;
            $display("FAIL multi_three got err=%0b cnt=%0d valid=%0b bus=%h want 1 3 0 %h",
                     err_multi, err_count, bus_valid, busMuxOut, held);
        end
        sel_valid = 0; err_clear = 1;
        tick();
        err_clear = 0;
        checks++;
        if (err_multi !== 1'b0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL err_clear got err=%0b cnt=%0d want 0 0", err_multi, err_count);
        end
        sel_valid = 1;
        for (int c = 0; c < 300; c++) begin
            registerSelect = 24'h3 << $urandom_range(0, 22);
            tick();
        end
        checks++;
        if (err_count !== 8'd255 || err_multi !== 1'b1) begin
            failures++;
            $display("FAIL err_saturate got cnt=%0d err=%0b want 255 1", err_count, err_multi);
        end
        err_clear = 1;
        tick();
        checks++;
        if (err_count !== 8'd1 || err_multi !== 1'b1) begin
            failures++;
            $display("FAIL clear_vs_error got cnt=%0d err=%0b want 1 1", err_count, err_multi);
        end
        sel_valid = 0;
        tick();
        err_clear = 0;
    endtask

    task automatic test_back_to_back();
        set_src(1, 32'd1); set_src(2, 32'd2); set_src(3, 32'd3);
        sel_valid = 1; bus_ready = 1;
        for (int k = 1; k <= 3; k++) begin
            registerSelect = 24'h1 << k;
            tick();
            checks++;
            if (busMuxOut !== 32'(k) || bus_valid !== 1'b1 || src_idx !== 5'(k)) begin
                failures++;
                $display("FAIL b2b_r%0d got bus=%h valid=%0b idx=%0d want %0d 1 %0d",
                         k, busMuxOut, bus_valid, src_idx, k, k);
            end
        end
        sel_valid = 0;
        tick();
        checks++;
        if (bus_valid !== 1'b0 || busMuxOut !== 32'd3 || src_idx !== 5'd3) begin
            failures++;
            $display("FAIL b2b_drain got valid=%0b bus=%h idx=%0d want 0 3 3",
                     bus_valid, busMuxOut, src_idx);
        end
    endtask

    task automatic test_reset_hold();
        set_src(5, 32'h00000007);
        registerSelect = 24'h1 << 5;
        sel_valid = 1; bus_ready = 0;
        tick();
`ifdef BUS_SOURCE_LATCH_PARITY_EN
        checks++;
        if (bus_parity !== 1'b1) begin
            failures++;
            $display("FAIL parity_7 got %0b want 1", bus_parity);
        end
`endif
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (bus_valid !== 1'b0 || busMuxOut !== 32'd0 || src_idx !== 5'd0) begin
            failures++;
            $display("FAIL reset_in_hold got valid=%0b bus=%h idx=%0d want 0 0 0",
                     bus_valid, busMuxOut, src_idx);
        end
        set_src(5, 32'h00000003);
        bus_ready = 1;
        tick();
        checks++;
        if (busMuxOut !== 32'h3 || bus_valid !== 1'b1) begin
            failures++;
            $display("FAIL load_3 got bus=%h valid=%0b want 3 1", busMuxOut, bus_valid);
        end
`ifdef BUS_SOURCE_LATCH_PARITY_EN
        checks++;
        if (bus_parity !== 1'b0) begin
            failures++;
            $display("FAIL parity_3 got %0b want 0", bus_parity);
        end
`endif
        sel_valid = 0;
        tick();
    endtask

    task automatic test_random();
        int kind;
        for (int c = 0; c < 600; c++) begin
            randomize_stream();
            kind = $urandom_range(0, 9);
            if (kind < 5)      registerSelect = 24'h1 << $urandom_range(0, SOURCES - 1);
            else if (kind < 7) registerSelect = '0;
            else               registerSelect = SOURCES'($urandom);
            sel_valid = 1'($urandom);
            bus_ready = ($urandom_range(0, 3) != 0);
            err_clear = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            #1;
            checks++;
            if (sel_ready !== (!mValid || bus_ready)) begin
                failures++;
                $display("FAIL rand_sel_ready cycle %0d got %0b want %0b", c, sel_ready, !mValid || bus_ready);
            end
            tick();
            checks++;
            if (bus_valid !== mValid || busMuxOut !== mBus || src_idx !== 5'(mIdx) ||
                err_multi !== mErr || err_count !== 8'(mCnt)) begin
                failures++;
                $display("FAIL rand_state cycle %0d got v=%0b bus=%h idx=%0d err=%0b cnt=%0d want v=%0b bus=%h idx=%0d err=%0b cnt=%0d",
                         c, bus_valid, busMuxOut, src_idx, err_multi, err_count,
                         mValid, mBus, mIdx, mErr, mCnt);
            end
`ifdef BUS_SOURCE_LATCH_PARITY_EN
            checks++;
            if (bus_parity !== ^mBus) begin
                failures++;
                $display("FAIL rand_parity cycle %0d got %0b want %0b", c, bus_parity, ^mBus);
            end
`endif
        end
        reset = 0; err_clear = 0; sel_valid = 0;
        tick();
    endtask

    initial begin
        mValid = 0; mBus = 0; mIdx = 0; mErr = 0; mCnt = 0;
        reset = 1; registerStream = '0; registerSelect = '0;
        sel_valid = 0; bus_ready = 0; err_clear = 0;
        @(negedge clk);
        test_reset();
        test_capture();
        test_backpressure();
        test_multi();
        test_back_to_back();
        test_reset_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
